// File: rtl/ram_param_clr_pkg.sv
// ram_param_clr_pkg: sweep-sequencer state encoding and default RAM geometry shared by the RAM family
package ram_param_clr_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_ADDR_W = 6;
endpackage

// File: rtl/ram_param_clr_if.sv
// ram_param_clr_if: user-side port bundle of the clearable single-port RAM
interface ram_param_clr_if
    import ram_param_clr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [ADDR_W-1:0] address;
    logic load;
    logic clear;
    logic busy;
    modport master (output in, load, address, clear, input out, busy);
    modport slave (input in, load, address, clear, output out, busy);
endinterface

// File: rtl/ram_param_clr_clear_seq.sv
// ram_param_clr_clear_seq: walks every address once, one per cycle, after reset or a clear request
module ram_param_clr_clear_seq
    import ram_param_clr_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);
    state_e state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    always_comb begin
        state_d = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            state_d = &clr_addr_q ? ST_IDLE : ST_CLEAR;
        end else if (clear) begin
            state_d = ST_CLEAR;
            clr_addr_d = '0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end
    assign busy = state_q == ST_CLEAR;
    // a held reset must leave the array alone, so the sweep only writes once released
    assign clr_we = busy & rst_n;
    assign clr_addr = clr_addr_q;
endmodule

// File: rtl/ram_param_clr.sv
// ram_param_clr: single-port RAM with combinational read and a hardware zeroing sweep
module ram_param_clr
    import ram_param_clr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic           clk,
    input logic           rst_n,
    ram_param_clr_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    logic [WIDTH-1:0] mem [DEPTH];
    logic busy, clr_we, we;
    logic [ADDR_W-1:0] clr_addr, waddr;
    logic [WIDTH-1:0] wdata;
    ram_param_clr_clear_seq #(.ADDR_W(ADDR_W)) u_seq (
        .clk(clk),
        .rst_n(rst_n),
        .clear(bus.clear),
        .busy(busy),
        .clr_we(clr_we),
        .clr_addr(clr_addr)
    );
    // the sweep owns the write port while busy; a clear request suppresses a same-cycle load
    assign we = clr_we | (rst_n & ~busy & ~bus.clear & bus.load);
    assign waddr = busy ? clr_addr : bus.address;
    assign wdata = busy ? '0 : bus.in;
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign bus.out = busy ? '0 : mem[bus.address];
    assign bus.busy = busy;
endmodule
